// File: rtl/cache_arbiter.sv
// Two-port arbiter/sequencer sharing one single-ported cache between instruction fetch (port 0) and data (port 1).
// Optional feature macro CACHE_ARB_RR_EN selects round-robin; when undefined, port 1 has fixed priority.
module cache_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  p0_valid,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic                  p0_read,
    input  logic                  p0_write,
    input  logic [DATA_WIDTH-1:0] p0_din,
    output logic                  p0_accept,
    output logic                  p0_resp_valid,

    input  logic                  p1_valid,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic                  p1_read,
    input  logic                  p1_write,
    input  logic [DATA_WIDTH-1:0] p1_din,
    output logic                  p1_accept,
    output logic                  p1_resp_valid,

    output logic [DATA_WIDTH-1:0] resp_dout,
    output logic                  resp_hit,

    output logic                  c_is_input_valid,
    output logic [ADDR_WIDTH-1:0] c_addr,
    output logic                  c_mem_read,
    output logic                  c_mem_write,
    output logic [DATA_WIDTH-1:0] c_din,
    input  logic                  c_is_ready,
    input  logic                  c_is_output_valid,
    input  logic [DATA_WIDTH-1:0] c_dout,
    input  logic                  c_is_hit,

    output logic [31:0]           access_count,
    output logic [31:0]           hit_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  read_q, read_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [31:0]           access_count_q, access_count_d;
    logic [31:0]           hit_count_q, hit_count_d;

    logic elig0;
    logic elig1;
    logic grant_any;
    logic grant_port;
    logic complete;

    // A request with read == write is malformed and simply never becomes eligible.
    assign elig0     = p0_valid & (p0_read ^ p0_write);
    assign elig1     = p1_valid & (p1_read ^ p1_write);
    assign grant_any = reset & (state_q == ST_IDLE) & c_is_ready & (elig0 | elig1);
    assign complete  = (state_q == ST_WAIT) & c_is_output_valid;

`ifdef CACHE_ARB_RR_EN
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (grant_any) begin
            last_d = grant_port;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    // On a tie the port that did not win last time is served.
    assign grant_port = (elig0 & elig1) ? ~last_q : elig1;
`else
    assign grant_port = elig1;
`endif

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned and no latch is inferred.
        state_d        = state_q;
        owner_d        = owner_q;
        addr_d         = addr_q;
        read_d         = read_q;
        write_d        = write_q;
        din_d          = din_q;
        access_count_d = access_count_q;
        hit_count_d    = hit_count_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    state_d = ST_ISSUE;
                    owner_d = grant_port;
                    addr_d  = grant_port ? p1_addr  : p0_addr;
                    read_d  = grant_port ? p1_read  : p0_read;
                    write_d = grant_port ? p1_write : p0_write;
                    din_d   = grant_port ? p1_din   : p0_din;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (c_is_output_valid) begin
                    state_d        = ST_IDLE;
                    access_count_d = access_count_q + 32'd1;
                    if (c_is_hit) begin
                        hit_count_d = hit_count_q + 32'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state is written with <= so every register samples pre-edge values.
        if (!reset) begin
            state_q        <= ST_IDLE;
            owner_q        <= 1'b0;
            addr_q         <= '0;
            read_q         <= 1'b0;
            write_q        <= 1'b0;
            din_q          <= '0;
            access_count_q <= '0;
            hit_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            addr_q         <= addr_d;
            read_q         <= read_d;
            write_q        <= write_d;
            din_q          <= din_d;
            access_count_q <= access_count_d;
            hit_count_q    <= hit_count_d;
        end
    end

    assign p0_accept        = grant_any & ~grant_port;
    assign p1_accept        = grant_any &  grant_port;

    // Responses are routed combinationally in the same cycle the cache reports completion.
    assign p0_resp_valid    = complete & ~owner_q;
    assign p1_resp_valid    = complete &  owner_q;
    assign resp_dout        = complete ? c_dout : '0;
    assign resp_hit         = complete & c_is_hit;

    assign c_is_input_valid = (state_q == ST_ISSUE);
    assign c_addr           = addr_q;
    assign c_mem_read       = read_q;
    assign c_mem_write      = write_q;
    assign c_din            = din_q;

    assign access_count     = access_count_q;
    assign hit_count        = hit_count_q;

`ifndef SYNTHESIS
    a_accept_onehot: assert property (@(posedge clk) disable iff (!reset)
        !(p0_accept && p1_accept));
    a_resp_onehot: assert property (@(posedge clk) disable iff (!reset)
        !(p0_resp_valid && p1_resp_valid));
    a_issue_follows_accept: assert property (@(posedge clk) disable iff (!reset)
        (p0_accept || p1_accept) |=> c_is_input_valid);
    a_issue_single_cycle: assert property (@(posedge clk) disable iff (!reset)
        c_is_input_valid |=> !c_is_input_valid);
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Honours CACHE_ARB_RR_EN the same way as the design (round-robin vs fixed port-1 priority).
`timescale 1ns/1ps
module tb_cache_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_valid, p0_read, p0_write, p0_accept, p0_resp_valid;
    logic [31:0] p0_addr, p0_din;
    logic        p1_valid, p1_read, p1_write, p1_accept, p1_resp_valid;
    logic [31:0] p1_addr, p1_din;
    logic [31:0] resp_dout;
    logic        resp_hit;
    logic        c_is_input_valid, c_mem_read, c_mem_write;
    logic [31:0] c_addr, c_din;
    logic        c_is_ready, c_is_output_valid, c_is_hit;
    logic [31:0] c_dout;
    logic [31:0] access_count, hit_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: last granted port and completion statistics.
    int          exp_last;
    logic [31:0] acc_m;
    logic [31:0] hit_m;

    typedef struct packed {
        logic        v;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] din;
    } req_t;

    always #5 clk = ~clk;

    cache_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_read(p0_read), .p0_write(p0_write),
        .p0_din(p0_din), .p0_accept(p0_accept), .p0_resp_valid(p0_resp_valid),
        .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_read(p1_read), .p1_write(p1_write),
        .p1_din(p1_din), .p1_accept(p1_accept), .p1_resp_valid(p1_resp_valid),
        .resp_dout(resp_dout), .resp_hit(resp_hit),
        .c_is_input_valid(c_is_input_valid), .c_addr(c_addr), .c_mem_read(c_mem_read),
        .c_mem_write(c_mem_write), .c_din(c_din), .c_is_ready(c_is_ready),
        .c_is_output_valid(c_is_output_valid), .c_dout(c_dout), .c_is_hit(c_is_hit),
        .access_count(access_count), .hit_count(hit_count)
    );

    // Winner for a cycle where the given ports are eligible and the cache is ready.
    function automatic int pick_winner(input bit e0, input bit e1);
        if (e0 && e1) begin
`ifdef CACHE_ARB_RR_EN
            return 1 - exp_last;
`else
            return 1;
`endif
        end
        return e1 ? 1 : 0;
    endfunction

    function automatic req_t new_req();
        req_t r;
        r.v    = ($urandom_range(0, 9) < 7);
        r.rd   = $urandom_range(0, 1);
        r.wr   = ($urandom_range(0, 7) == 0) ? r.rd : ~r.rd;
        r.addr = $urandom;
        r.din  = $urandom;
        return r;
    endfunction

    task automatic drive_idle();
        p0_valid = 0; p0_read = 0; p0_write = 0; p0_addr = '0; p0_din = '0;
        p1_valid = 0; p1_read = 0; p1_write = 0; p1_addr = '0; p1_din = '0;
        c_is_ready = 1; c_is_output_valid = 0; c_dout = '0; c_is_hit = 0;
    endtask

    task automatic model_reset();
        exp_last = 1;
        acc_m    = '0;
        hit_m    = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        drive_idle();
        reset = 0;
        repeat (2) @(negedge clk);
        reset = 1;
        model_reset();
    endtask

    task automatic drive_port(input int port, input bit v, input bit rd, input bit wr,
                              input logic [31:0] addr, input logic [31:0] din);
        if (port == 0) begin
            p0_valid = v; p0_read = rd; p0_write = wr; p0_addr = addr; p0_din = din;
        end else begin
            p1_valid = v; p1_read = rd; p1_write = wr; p1_addr = addr; p1_din = din;
        end
    endtask

    // One complete single-requester transaction with the model idle beforehand.
    task automatic do_txn(input string tag, input int port, input bit rd, input bit wr,
                          input logic [31:0] addr, input logic [31:0] din, input int latency,
                          input logic [31:0] dout, input bit hit);
        logic [1:0] exp_acc;
        @(negedge clk);
        drive_port(port, 1, rd, wr, addr, din);
        c_is_ready = 1;
        #1;
        exp_acc = (pick_winner(port == 0, port == 1) == 1) ? 2'b10 : 2'b01;
        n_cmp++;
        if ({p1_accept, p0_accept} !== exp_acc) begin
            n_bad++;
            $display("FAIL %s_accept got=%b exp=%b", tag, {p1_accept, p0_accept}, exp_acc);
        end
        @(posedge clk);
        exp_last = port;
        @(negedge clk);
        drive_port(port, 0, 0, 0, '0, '0);
        #1;
        n_cmp++;
        if ({c_is_input_valid, c_addr, c_mem_read, c_mem_write, c_din} !== {1'b1, addr, rd, wr, din}) begin
            n_bad++;
            $display("FAIL %s_issue got iv=%b a=%h r=%b w=%b d=%h exp a=%h r=%b w=%b d=%h", tag,
                     c_is_input_valid, c_addr, c_mem_read, c_mem_write, c_din, addr, rd, wr, din);
        end
        for (int i = 0; i < latency; i++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if ({c_is_input_valid, p0_resp_valid, p1_resp_valid, c_addr, c_mem_write, c_din} !==
                {3'b000, addr, wr, din}) begin
                n_bad++;
                $display("FAIL %s_wait cyc=%0d got iv=%b rv=%b%b a=%h w=%b d=%h exp held a=%h w=%b d=%h", tag, i,
                         c_is_input_valid, p1_resp_valid, p0_resp_valid, c_addr, c_mem_write, c_din, addr, wr, din);
            end
        end
        @(negedge clk);
        c_is_output_valid = 1; c_dout = dout; c_is_hit = hit;
        #1;
        n_cmp++;
        if ({p1_resp_valid, p0_resp_valid, resp_dout, resp_hit} !==
            {(port == 1), (port == 0), dout, hit}) begin
            n_bad++;
            $display("FAIL %s_resp got rv=%b%b d=%h h=%b exp port=%0d d=%h h=%b", tag,
                     p1_resp_valid, p0_resp_valid, resp_dout, resp_hit, port, dout, hit);
        end
        @(posedge clk);
        acc_m = acc_m + 32'd1;
        if (hit) hit_m = hit_m + 32'd1;
        @(negedge clk);
        c_is_output_valid = 0; c_dout = '0; c_is_hit = 0;
        #1;
        n_cmp++;
        if ({access_count, hit_count, p0_resp_valid, p1_resp_valid, resp_dout, resp_hit} !==
            {acc_m, hit_m, 2'b00, 32'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL %s_after got acc=%h hit=%h rv=%b%b d=%h exp acc=%h hit=%h and quiet resp", tag,
                     access_count, hit_count, p1_resp_valid, p0_resp_valid, resp_dout, acc_m, hit_m);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        p0_valid = 1; p0_read = 1; p0_addr = 32'h55;
        reset = 0;
        model_reset();
        @(negedge clk);
        #1;
        n_cmp++;
        if ({p0_accept, p1_accept, p0_resp_valid, p1_resp_valid, resp_dout, resp_hit, c_is_input_valid,
             c_addr, c_mem_read, c_mem_write, c_din, access_count, hit_count} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got acc=%b%b iv=%b a=%h cnt=%h/%h exp all zero",
                     p1_accept, p0_accept, c_is_input_valid, c_addr, access_count, hit_count);
        end
        @(negedge clk);
        drive_idle();
        reset = 1;
    endtask

    task automatic test_basic_hit();
        do_txn("basic_hit", 0, 1, 0, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1);
        n_cmp++;
        if ({access_count, hit_count} !== {32'd1, 32'd1}) begin
            n_bad++;
            $display("FAIL basic_counts got %0d/%0d exp 1/1", access_count, hit_count);
        end
    endtask

    task automatic test_write_miss();
        do_txn("write_miss", 1, 0, 1, 32'h40, 32'h12345678, 20, 32'h0, 0);
    endtask

    task automatic test_arbitration();
        int         w;
        logic [1:0] exp_acc;
        logic [31:0] dv;
        apply_reset();
        @(negedge clk);
        drive_port(0, 1, 1, 0, 32'h1000, '0);
        drive_port(1, 1, 1, 0, 32'h2000, '0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                @(negedge clk);
                c_is_output_valid = 0;
            end
            #1;
            w = pick_winner(1, 1);
            exp_acc = (w == 1) ? 2'b10 : 2'b01;
            n_cmp++;
            if ({p1_accept, p0_accept} !== exp_acc) begin
                n_bad++;
                $display("FAIL arb_grant k=%0d got=%b exp=%b", k, {p1_accept, p0_accept}, exp_acc);
            end
            @(posedge clk);
            exp_last = w;
            @(negedge clk);
            #1;
            n_cmp++;
            if ({c_is_input_valid, c_addr} !== {1'b1, (w == 1) ? 32'h2000 : 32'h1000}) begin
                n_bad++;
                $display("FAIL arb_issue k=%0d got iv=%b a=%h exp port %0d", k, c_is_input_valid, c_addr, w);
            end
            @(negedge clk);
            dv = $urandom;
            c_is_output_valid = 1; c_dout = dv; c_is_hit = k[0];
            #1;
            n_cmp++;
            if ({p1_resp_valid, p0_resp_valid, resp_dout} !== {(w == 1), (w == 0), dv}) begin
                n_bad++;
                $display("FAIL arb_resp k=%0d got rv=%b%b d=%h exp port %0d d=%h", k,
                         p1_resp_valid, p0_resp_valid, resp_dout, w, dv);
            end
            @(posedge clk);
            acc_m = acc_m + 32'd1;
            if (k[0]) hit_m = hit_m + 32'd1;
        end
        @(negedge clk);
        drive_idle();
        #1;
        n_cmp++;
        if ({access_count, hit_count} !== {acc_m, hit_m}) begin
            n_bad++;
            $display("FAIL arb_counts got %0d/%0d exp %0d/%0d", access_count, hit_count, acc_m, hit_m);
        end
    endtask

    task automatic test_not_ready_illegal();
        @(negedge clk);
        drive_port(0, 1, 1, 0, 32'hABC0, '0);
        c_is_ready = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            n_cmp++;
            if ({p1_accept, p0_accept, c_is_input_valid} !== 3'b000) begin
                n_bad++;
                $display("FAIL not_ready cyc=%0d got acc=%b%b iv=%b exp none", i, p1_accept, p0_accept, c_is_input_valid);
            end
        end
        do_txn("ready_back", 0, 1, 0, 32'hABC0, '0, 2, 32'h0BADF00D, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive_port(0, 1, (i < 4), (i < 4), $urandom, $urandom);
            c_is_ready = 1;
            #1;
            n_cmp++;
            if ({p1_accept, p0_accept} !== 2'b00) begin
                n_bad++;
                $display("FAIL illegal_rw cyc=%0d got acc=%b%b exp none", i, p1_accept, p0_accept);
            end
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_reset_mid();
        do_txn("pre_mid", 0, 1, 0, 32'h300, '0, 0, 32'h77, 1);
        @(negedge clk);
        drive_port(1, 1, 1, 0, 32'h7700, '0);
        #1;
        n_cmp++;
        if ({p1_accept, p0_accept} !== 2'b10) begin
            n_bad++;
            $display("FAIL mid_accept got=%b exp=10", {p1_accept, p0_accept});
        end
        @(negedge clk);
        drive_port(1, 0, 0, 0, '0, '0);
        @(negedge clk);
        #2;
        reset = 0;
        drive_port(0, 1, 1, 0, 32'h44, '0);
        c_is_output_valid = 1; c_dout = 32'hFFFF0000; c_is_hit = 1;
        #1;
        n_cmp++;
        if ({p0_accept, p1_accept, p0_resp_valid, p1_resp_valid, resp_dout, resp_hit, c_is_input_valid,
             c_addr, c_mem_read, c_mem_write, c_din, access_count, hit_count} !== '0) begin
            n_bad++;
            $display("FAIL mid_reset got rv=%b%b d=%h a=%h cnt=%h/%h exp all zero",
                     p1_resp_valid, p0_resp_valid, resp_dout, c_addr, access_count, hit_count);
        end
        @(negedge clk);
        drive_idle();
        reset = 1;
        model_reset();
        do_txn("post_mid", 0, 0, 1, 32'h88, 32'hCAFE, 1, 32'h0, 1);
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.access_count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.access_count_q;
        acc_m = 32'hFFFF_FFFF;
        #1;
        n_cmp++;
        if (access_count !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL wrap_preload got=%h exp=ffffffff", access_count);
        end
        do_txn("wrap", 1, 1, 0, 32'h9000, '0, 0, 32'h1, 1);
        n_cmp++;
        if (access_count !== 32'd0) begin
            n_bad++;
            $display("FAIL wrap_zero got=%h exp=00000000", access_count);
        end
    endtask

    task automatic test_random();
        req_t        r0, r1, lat;
        int          phase, wait_left, owner, w;
        bit          ov, hit_v, e0, e1, accepted;
        logic [31:0] dout_v;
        logic [1:0]  exp_acc, exp_resp;
        apply_reset();
        r0 = new_req(); r1 = new_req(); lat = '0;
        phase = 0; wait_left = 0; owner = 0; w = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            drive_port(0, r0.v, r0.rd, r0.wr, r0.addr, r0.din);
            drive_port(1, r1.v, r1.rd, r1.wr, r1.addr, r1.din);
            c_is_ready = ($urandom_range(0, 3) != 0);
            ov = (phase == 2) ? (wait_left == 0) : ($urandom_range(0, 9) == 0);
            dout_v = $urandom; hit_v = $urandom_range(0, 1);
            c_is_output_valid = ov; c_dout = dout_v; c_is_hit = hit_v;
            #1;
            exp_acc = 2'b00; exp_resp = 2'b00; accepted = 0;
            if (phase == 0) begin
                e0 = r0.v && (r0.rd ^ r0.wr);
                e1 = r1.v && (r1.rd ^ r1.wr);
                if (c_is_ready && (e0 || e1)) begin
                    w = pick_winner(e0, e1);
                    exp_acc[w] = 1'b1;
                    accepted = 1;
                end
            end
            if (phase == 2 && ov) exp_resp[owner] = 1'b1;
            n_cmp++;
            if ({p1_accept, p0_accept, p1_resp_valid, p0_resp_valid, c_is_input_valid} !==
                {exp_acc, exp_resp, (phase == 1)}) begin
                n_bad++;
                $display("FAIL rand_ctrl cyc=%0d got acc=%b%b rv=%b%b iv=%b exp acc=%b rv=%b iv=%b", cyc,
                         p1_accept, p0_accept, p1_resp_valid, p0_resp_valid, c_is_input_valid,
                         exp_acc, exp_resp, (phase == 1));
            end
            n_cmp++;
            if ({resp_dout, resp_hit, access_count, hit_count} !==
                {(exp_resp != 0) ? dout_v : 32'd0, (exp_resp != 0) && hit_v, acc_m, hit_m}) begin
                n_bad++;
                $display("FAIL rand_data cyc=%0d got d=%h h=%b cnt=%h/%h exp cnt=%h/%h", cyc,
                         resp_dout, resp_hit, access_count, hit_count, acc_m, hit_m);
            end
            if (phase != 0) begin
                n_cmp++;
                if ({c_addr, c_mem_read, c_mem_write, c_din} !== {lat.addr, lat.rd, lat.wr, lat.din}) begin
                    n_bad++;
                    $display("FAIL rand_fields cyc=%0d got a=%h r=%b w=%b d=%h exp a=%h r=%b w=%b d=%h", cyc,
                             c_addr, c_mem_read, c_mem_write, c_din, lat.addr, lat.rd, lat.wr, lat.din);
                end
            end
            @(posedge clk);
            if (phase == 0 && accepted) begin
                lat = (w == 1) ? r1 : r0;
                owner = w;
                exp_last = w;
                phase = 1;
                if (w == 1) r1 = new_req(); else r0 = new_req();
            end else if (phase == 1) begin
                phase = 2;
                wait_left = $urandom_range(0, 4);
            end else if (phase == 2) begin
                if (ov) begin
                    acc_m = acc_m + 32'd1;
                    if (hit_v) hit_m = hit_m + 32'd1;
                    phase = 0;
                end else begin
                    wait_left--;
                end
            end
            if (!(accepted && w == 0) && (!r0.v || !(r0.rd ^ r0.wr)) && $urandom_range(0, 2) == 0) r0 = new_req();
            if (!(accepted && w == 1) && (!r1.v || !(r1.rd ^ r1.wr)) && $urandom_range(0, 2) == 0) r1 = new_req();
        end
        @(negedge clk);
        drive_idle();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_basic_hit();
        test_write_miss();
        test_arbitration();
        test_not_ready_illegal();
        test_reset_mid();
        test_wrap();
        test_random();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
